pool_channel_scheduler: RTL and testbench
=========================================

POOL_CHANNEL_SCHEDULER -- requirements
Module: pool_channel_scheduler

Interface
REQ-001 SHALL have parameter NCH, default 4, number of requesting feature-map channels.
REQ-002 SHALL have parameter ROW_W, default 24, pixels per input row.
REQ-003 SHALL have parameter FRAME_PIX, default 576 (ROW_W*ROW_W), input beats per frame.
REQ-004 SHALL have parameter POOL_OUT, default 144 (FRAME_PIX/4), pooled outputs per frame.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 resetn  in  1  reset, synchronous and active-low.
REQ-007 en  in  1  grant enable; low blocks new grants, the current frame completes.
REQ-008 ch_d  in  2*NCH  packed signed ternary pixels, channel k at bits [2k+1:2k].
REQ-009 ch_v  in  NCH  per-channel pixel valid.
REQ-010 ch_rdy  out  NCH  per-channel accept; beat transfers when ch_v[k] and ch_rdy[k] are both high.
REQ-011 pool_d  out  2  signed pixel to the shared 2x2 pooling unit.
REQ-012 pool_v  out  1  pixel valid to the pooling unit.
REQ-013 pool_od  in  2  signed pooled result from the pooling unit.
REQ-014 pool_ov  in  1  pooled result valid from the pooling unit.
REQ-015 out_d  out  2  signed pooled result, registered.
REQ-016 out_v  out  1  out_d valid.
REQ-017 out_ch  out  clog2(NCH)  channel that owns out_d.
REQ-018 out_last  out  1  high with the last (POOL_OUT-th) result of a frame.
REQ-019 busy  out  1  high in any state other than IDLE.
REQ-020 frame_done  out  1  one-cycle pulse when a frame is fully drained.

Function
REQ-021 SHALL implement FSM states IDLE, STREAM and DRAIN.
REQ-022 IDLE: when en=1 and any ch_v is high, grant one channel round-robin, starting the search at the channel after the last one served, latch grant, then go to STREAM.
REQ-023 Grant SHALL persist for exactly one whole frame; a frame SHALL never be interleaved with another channel's frame.
REQ-024 STREAM: ch_rdy[grant]=1; all other ch_rdy bits 0; ch_rdy = 0 in IDLE and DRAIN.
REQ-025 Each accepted beat SHALL drive pool_d and pool_v=1 on the next cycle (1-cycle latency); otherwise pool_v=0 and pool_d holds.
REQ-026 in_cnt (10 bits) SHALL count accepted beats; ch_v gaps hold the count with no timeout.
REQ-027 On the FRAME_PIX-th accepted beat SHALL clear in_cnt and go to DRAIN.
REQ-028 out_cnt (8 bits) SHALL count pool_ov pulses in STREAM and DRAIN.
REQ-029 out_d/out_v SHALL equal pool_od/pool_ov delayed one cycle; out_ch=grant; out_last=1 when out_cnt was POOL_OUT-1.
REQ-030 DRAIN: after the POOL_OUT-th pool_ov, SHALL pulse frame_done, clear out_cnt, set last-served pointer = grant, and go to IDLE.
REQ-031 At least one IDLE cycle SHALL separate frames.
REQ-032 pool_ov while in IDLE SHALL be ignored: not counted and not forwarded.
REQ-033 en falling mid-frame SHALL NOT abort the frame.
REQ-034 Simultaneous requests SHALL be served in rotating order; with all NCH channels requesting continuously, each SHALL be served once per NCH frames.
REQ-035 Pointer wrap SHALL go NCH-1 -> 0.

Reset
REQ-036 On resetn=0 at a clock edge: state=IDLE, in_cnt=0, out_cnt=0, pointer=NCH-1 (so channel 0 wins first), grant=0.
REQ-037 On resetn=0, all outputs (ch_rdy, pool_d, pool_v, out_d, out_v, out_ch, out_last, busy, frame_done) SHALL be 0.
REQ-038 Reset mid-frame SHALL discard the partial frame; the pooling unit SHALL share the same resetn so its line state is cleared too.

Structure
REQ-039 Package pool_sched_pkg SHALL hold NCH, ROW_W, FRAME_PIX and POOL_OUT defaults plus the FSM state encoding.
REQ-040 Sub-module rr_arbiter (NCH-way, pointer input, one-hot grant output) SHALL be instantiated once; the pooling unit SHALL be instantiated outside this block.

Verification
REQ-041 Only ch1 streams 576 beats with no gaps -> grant=1, 576 pool_v pulses, 144 out_v with out_ch=1, out_last on the 144th, one frame_done.
REQ-042 ch0..ch3 request together from reset -> frames served in order 0,1,2,3, then 0 again; ch_rdy never has more than one bit set.
REQ-043 Random ch_v gaps on the granted channel (~30% idle) -> in_cnt reaches 576 exactly once, pool_d matches the accepted data in order.
REQ-044 en=0 with ch2 requesting -> ch_rdy=0, busy=0; en dropped at beat 300 -> frame still completes with 144 results.
REQ-045 resetn low at beat 400 -> all outputs 0 the next cycle; a new frame from ch0 after reset yields exactly 144 correct results.
REQ-046 Frame of all +1 except one -1 in each 2x2 window -> all 144 out_d=+1; frame of all -1 -> all 144 out_d=-1.

Source files
------------

// File: rtl/pool_sched_pkg.sv
// Shared defaults and FSM encoding for the pooling channel scheduler.
package pool_sched_pkg;

  localparam int unsigned NchDef      = 4;
  localparam int unsigned RowWDef     = 24;
  localparam int unsigned FramePixDef = RowWDef * RowWDef;
  localparam int unsigned PoolOutDef  = FramePixDef / 4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StStream = 2'd1,
    StDrain  = 2'd2
  } sched_state_e;

  // Channel index width; a single channel still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_channel_scheduler_if.sv
// Channel request bus, pooling-unit link and pooled result stream.
interface pool_channel_scheduler_if import pool_sched_pkg::*; #(
  parameter int unsigned NCH = NchDef
) ();

  localparam int unsigned IdxW = idx_width(NCH);

  logic [2*NCH-1:0] ch_d;
  logic [NCH-1:0]   ch_v;
  logic [NCH-1:0]   ch_rdy;
  logic signed [1:0] pool_d;
  logic             pool_v;
  logic signed [1:0] pool_od;
  logic             pool_ov;
  logic signed [1:0] out_d;
  logic             out_v;
  logic [IdxW-1:0]  out_ch;
  logic             out_last;

  // Environment side: channels and pooling unit.
  modport master (
    output ch_d, ch_v, pool_od, pool_ov,
    input  ch_rdy, pool_d, pool_v, out_d, out_v, out_ch, out_last
  );

  // Scheduler side.
  modport slave (
    input  ch_d, ch_v, pool_od, pool_ov,
    output ch_rdy, pool_d, pool_v, out_d, out_v, out_ch, out_last
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last-served pointer.
module rr_arbiter #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NCH-1:0]  req,
  input  logic [IdxW-1:0] ptr,
  output logic [NCH-1:0]  gnt
);

  logic [IdxW-1:0] idx;
  logic            found;

  // First requester found walking ptr+1, ptr+2, ... with wrap NCH-1 -> 0.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 1; i <= NCH; i++) begin
      idx = IdxW'((32'(ptr) + i) % NCH);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pool_channel_scheduler.sv
// Time-shares one 2x2 pooling unit between NCH channels, one whole frame at a time.
module pool_channel_scheduler import pool_sched_pkg::*; #(
  parameter int unsigned NCH       = NchDef,
  parameter int unsigned ROW_W     = RowWDef,
  parameter int unsigned FRAME_PIX = FramePixDef,
  parameter int unsigned POOL_OUT  = PoolOutDef
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  output logic busy,
  output logic frame_done,
  pool_channel_scheduler_if.slave bus
);

  localparam int unsigned IdxW = idx_width(NCH);

  if ((FRAME_PIX != ROW_W * ROW_W) || (POOL_OUT != FRAME_PIX / 4)) begin : g_cfg_check
    $error("pool_channel_scheduler: inconsistent frame geometry");
  end

  sched_state_e      state_q;
  logic [9:0]        in_cnt_q;
  logic [7:0]        out_cnt_q;
  logic [IdxW-1:0]   ptr_q;
  logic [IdxW-1:0]   grant_q;
  logic [NCH-1:0]    gnt;
  logic [IdxW-1:0]   gnt_idx;
  logic              beat;
  logic signed [1:0] ch_pix;

  rr_arbiter #(
    .NCH  (NCH),
    .IdxW (IdxW)
  ) u_arb (
    .req (bus.ch_v),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // One-hot arbiter grant to channel index.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (gnt[IdxW'(k)]) gnt_idx = IdxW'(k);
    end
  end

  assign beat   = (state_q == StStream) && bus.ch_v[grant_q];
  assign ch_pix = bus.ch_d[{grant_q, 1'b0} +: 2];
  assign busy   = (state_q != StIdle);

  // Only the granted channel is ever ready, and only while streaming.
  always_comb begin
    bus.ch_rdy = '0;
    if (state_q == StStream) bus.ch_rdy[grant_q] = 1'b1;
  end

  // Frame FSM with registered pool feed and result forwarding.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q        <= StIdle;
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      ptr_q          <= IdxW'(NCH - 1);
      grant_q        <= '0;
      bus.pool_d     <= '0;
      bus.pool_v     <= 1'b0;
      bus.out_d      <= '0;
      bus.out_v      <= 1'b0;
      bus.out_ch     <= '0;
      bus.out_last   <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      bus.pool_v   <= 1'b0;
      bus.out_v    <= 1'b0;
      bus.out_last <= 1'b0;
      frame_done   <= 1'b0;

      // Results arriving while idle belong to no frame and are dropped.
      if ((state_q != StIdle) && bus.pool_ov) begin
        bus.out_v    <= 1'b1;
        bus.out_d    <= bus.pool_od;
        bus.out_ch   <= grant_q;
        bus.out_last <= (out_cnt_q == 8'(POOL_OUT - 1));
      end

      unique case (state_q)
        StIdle: begin
          if (en && (|bus.ch_v)) begin
            grant_q <= gnt_idx;
            state_q <= StStream;
          end
        end
        StStream: begin
          if (beat) begin
            bus.pool_d <= ch_pix;
            bus.pool_v <= 1'b1;
            if (in_cnt_q == 10'(FRAME_PIX - 1)) begin
              in_cnt_q <= '0;
              state_q  <= StDrain;
            end else begin
              in_cnt_q <= in_cnt_q + 10'd1;
            end
          end
          if (bus.pool_ov) out_cnt_q <= out_cnt_q + 8'd1;
        end
        StDrain: begin
          if (bus.pool_ov) begin
            if (out_cnt_q == 8'(POOL_OUT - 1)) begin
              out_cnt_q  <= '0;
              frame_done <= 1'b1;
              ptr_q      <= grant_q;
              state_q    <= StIdle;
            end else begin
              out_cnt_q <= out_cnt_q + 8'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_channel_scheduler.sv
// Scoreboard bench for pool_channel_scheduler with a behavioural 2x2 max-pool unit.
module tb_pool_channel_scheduler;
  import pool_sched_pkg::*;

  localparam int unsigned NCH       = NchDef;
  localparam int unsigned ROW_W     = RowWDef;
  localparam int unsigned FRAME_PIX = FramePixDef;
  localparam int unsigned POOL_OUT  = PoolOutDef;

  typedef logic signed [1:0] pix_t;
  typedef struct {
    int d;
    int ch;
    int last;
  } exp_out_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0;
  logic busy;
  logic frame_done;

  pool_channel_scheduler_if #(.NCH(NCH)) bus ();

  pool_channel_scheduler #(
    .NCH       (NCH),
    .ROW_W     (ROW_W),
    .FRAME_PIX (FRAME_PIX),
    .POOL_OUT  (POOL_OUT)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .en         (en),
    .busy       (busy),
    .frame_done (frame_done),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pool_v_cnt = 0;
  int out_v_cnt = 0;
  int last_cnt = 0;
  int done_cnt = 0;
  int last_out_ch = -1;
  int exp_pool[$];
  exp_out_t exp_out[$];
  int done_order[$];

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Pooling unit model: row-major stream, emits max of each 2x2 window.
  pix_t pm_part [ROW_W/2];
  int   pm_pos;
  pix_t pm_od;
  logic pm_ov;
  assign bus.pool_od = pm_od;
  assign bus.pool_ov = pm_ov;

  always @(posedge clk) begin
    if (!resetn) begin
      pm_pos <= 0;
      pm_ov  <= 1'b0;
      pm_od  <= '0;
    end else begin
      pm_ov <= 1'b0;
      if (bus.pool_v) begin
        if (((pm_pos / ROW_W) % 2) == 0) begin
          if (((pm_pos % ROW_W) % 2) == 0) pm_part[(pm_pos % ROW_W) / 2] <= bus.pool_d;
          else pm_part[(pm_pos % ROW_W) / 2] <=
              pix_t'(max2(int'(pm_part[(pm_pos % ROW_W) / 2]), int'(bus.pool_d)));
        end else if (((pm_pos % ROW_W) % 2) == 0) begin
          pm_part[(pm_pos % ROW_W) / 2] <=
              pix_t'(max2(int'(pm_part[(pm_pos % ROW_W) / 2]), int'(bus.pool_d)));
        end else begin
          pm_od <= pix_t'(max2(int'(pm_part[(pm_pos % ROW_W) / 2]), int'(bus.pool_d)));
          pm_ov <= 1'b1;
        end
        pm_pos <= (pm_pos == FRAME_PIX - 1) ? 0 : pm_pos + 1;
      end
    end
  end

  // Output monitor: pops the scoreboard whenever the DUT presents data.
  initial begin
    exp_out_t e;
    forever begin
      @(posedge clk);
      #1;
      check_eq("rdy_onehot", int'($countones(bus.ch_rdy) <= 1), 1);
      if (bus.pool_v) begin
        pool_v_cnt++;
        if (exp_pool.size() == 0) check_eq("pool_v_unexpected", int'(bus.pool_v), 0);
        else check_eq("pool_d", int'(bus.pool_d), exp_pool.pop_front());
      end
      if (bus.out_v) begin
        out_v_cnt++;
        if (bus.out_last) last_cnt++;
        last_out_ch = int'(bus.out_ch);
        if (exp_out.size() == 0) begin
          check_eq("out_v_unexpected", int'(bus.out_v), 0);
        end else begin
          e = exp_out.pop_front();
          check_eq("out_d", int'(bus.out_d), e.d);
          check_eq("out_ch", int'(bus.out_ch), e.ch);
          check_eq("out_last", int'(bus.out_last), e.last);
        end
      end
      if (frame_done) begin
        done_cnt++;
        done_order.push_back(last_out_ch);
      end
    end
  end

  task automatic check_outputs_zero(input string pfx);
    check_eq({pfx, "_ch_rdy"}, int'(bus.ch_rdy), 0);
    check_eq({pfx, "_pool_d"}, int'(bus.pool_d), 0);
    check_eq({pfx, "_pool_v"}, int'(bus.pool_v), 0);
    check_eq({pfx, "_out_d"}, int'(bus.out_d), 0);
    check_eq({pfx, "_out_v"}, int'(bus.out_v), 0);
    check_eq({pfx, "_out_ch"}, int'(bus.out_ch), 0);
    check_eq({pfx, "_out_last"}, int'(bus.out_last), 0);
    check_eq({pfx, "_busy"}, int'(busy), 0);
    check_eq({pfx, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Streams one frame on channel ch. mode 0: random ternary, 1: +1 with one -1
  // per window, 2: all -1. Optional en drop and reset at a given beat index.
  task automatic drive_frame(input int ch, input int mode, input bit gaps,
                             input int en_drop, input int rst_at);
    pix_t fr [FRAME_PIX];
    exp_out_t e;
    int idx = 0;
    int budget = 0;
    int k, b;
    for (int i = 0; i < FRAME_PIX; i++) begin
      if (mode == 0) fr[i] = pix_t'(int'($urandom_range(0, 2)) - 1);
      else if (mode == 1) fr[i] = pix_t'(1);
      else fr[i] = pix_t'(-1);
    end
    if (mode == 1) begin
      for (int w = 0; w < POOL_OUT; w++) begin
        k = int'($urandom_range(0, 3));
        b = 2 * (w / (ROW_W / 2)) * ROW_W + 2 * (w % (ROW_W / 2));
        fr[b + (k / 2) * ROW_W + (k % 2)] = pix_t'(-1);
      end
    end
    while (idx < FRAME_PIX && budget < 8000) begin
      @(negedge clk);
      budget++;
      if (idx == rst_at) begin
        resetn = 1'b0;
        bus.ch_v[ch] = 1'b0;
        @(posedge clk);
        #1;
        check_outputs_zero("midrst");
        @(negedge clk);
        resetn = 1'b1;
        exp_pool.delete();
        exp_out.delete();
        return;
      end
      if (idx == en_drop) en = 1'b0;
      if (gaps && $urandom_range(0, 99) < 30) begin
        bus.ch_v[ch] = 1'b0;
      end else begin
        bus.ch_v[ch] = 1'b1;
        bus.ch_d[2*ch +: 2] = fr[idx];
        if (bus.ch_rdy[ch]) begin
          if (idx == 0) begin
            for (int w = 0; w < POOL_OUT; w++) begin
              b = 2 * (w / (ROW_W / 2)) * ROW_W + 2 * (w % (ROW_W / 2));
              e.d = max2(max2(int'(fr[b]), int'(fr[b+1])),
                         max2(int'(fr[b+ROW_W]), int'(fr[b+ROW_W+1])));
              e.ch = ch;
              e.last = (w == POOL_OUT - 1) ? 1 : 0;
              exp_out.push_back(e);
            end
          end
          exp_pool.push_back(int'(fr[idx]));
          idx++;
        end
      end
    end
    check_eq("drive_beats", idx, FRAME_PIX);
    @(negedge clk);
    bus.ch_v[ch] = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    while (done_cnt < target && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("done_reached", int'(done_cnt >= target), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_single(input int ch, input int mode, input bit gaps, input int en_drop);
    int p0, o0, l0, d0;
    p0 = pool_v_cnt;
    o0 = out_v_cnt;
    l0 = last_cnt;
    d0 = done_cnt;
    drive_frame(ch, mode, gaps, en_drop, -1);
    wait_done(d0 + 1);
    check_eq("frame_pool_v", pool_v_cnt - p0, FRAME_PIX);
    check_eq("frame_out_v", out_v_cnt - o0, POOL_OUT);
    check_eq("frame_last", last_cnt - l0, 1);
    check_eq("frame_done", done_cnt - d0, 1);
    check_eq("frame_owner", last_out_ch, ch);
    check_eq("sb_pool_empty", exp_pool.size(), 0);
    check_eq("sb_out_empty", exp_out.size(), 0);
  endtask

  initial begin
    int exp_order [5] = '{0, 1, 2, 3, 0};
    int d0;
    bus.ch_d = '0;
    bus.ch_v = '0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("rst");
    @(negedge clk);
    resetn = 1'b1;
    en = 1'b1;

    // All four channels request together from reset.
    d0 = done_cnt;
    done_order.delete();
    fork
      begin
        drive_frame(0, 0, 1'b0, -1, -1);
        drive_frame(0, 0, 1'b0, -1, -1);
      end
      drive_frame(1, 0, 1'b0, -1, -1);
      drive_frame(2, 0, 1'b0, -1, -1);
      drive_frame(3, 0, 1'b0, -1, -1);
    join
    wait_done(d0 + 5);
    check_eq("rr_frames", done_cnt - d0, 5);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("rr_order%0d", i),
               (i < done_order.size()) ? done_order[i] : -1, exp_order[i]);
    end

    // Single channel, no gaps.
    run_single(1, 0, 1'b0, -1);

    // Granted channel with random valid gaps.
    run_single(3, 0, 1'b1, -1);

    // Enable low blocks the grant; dropping it mid-frame does not abort.
    en = 1'b0;
    bus.ch_v[2] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_eq("en_low_rdy", int'(bus.ch_rdy), 0);
      check_eq("en_low_busy", int'(busy), 0);
    end
    en = 1'b1;
    run_single(2, 0, 1'b0, 300);
    en = 1'b1;

    // Reset partway through a frame, then a clean frame from channel 0.
    drive_frame(0, 0, 1'b0, -1, 400);
    run_single(0, 0, 1'b0, -1);

    // Window-pattern frames.
    run_single(1, 1, 1'b0, -1);
    run_single(2, 2, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
